// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU), one restoring step per cycle.
// Define DIV_FAST_SPECIAL_EN to retire divide-by-zero and signed overflow without iterating.
module div_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [1:0]      op_sel_i,
  input  logic [XLEN-1:0] opr_a_i,
  input  logic [XLEN-1:0] opr_b_i,
  input  logic            flush_i,
  output logic            ready_o,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] res_o
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q;
  logic [1:0]      op_q;
  logic            sa_q, sb_q, dz_q, ov_q;
  logic [XLEN-1:0] a_orig_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN:0]   rem_q;
  logic [XLEN-1:0] dvs_q;
  logic [4:0]      cnt_q;
  logic [XLEN-1:0] res_stage_q;
  logic [XLEN-1:0] res_q;

  // Accept-side decode
  logic            sa_in, sb_in, dz_in, ov_in, accept;
  logic [XLEN-1:0] mag_a, mag_b;

  always_comb begin
    sa_in  = ~op_sel_i[0] & opr_a_i[XLEN-1];
    sb_in  = ~op_sel_i[0] & opr_b_i[XLEN-1];
    mag_a  = sa_in ? (~opr_a_i + 1'b1) : opr_a_i;
    mag_b  = sb_in ? (~opr_b_i + 1'b1) : opr_b_i;
    dz_in  = (opr_b_i == '0);
    ov_in  = ~op_sel_i[0] & (opr_a_i == MinNeg) & (opr_b_i == '1);
    accept = (state_q == StIdle) & start_i & ~flush_i;
  end

  // One restoring step; the extra top bit of shifted/trial catches the borrow.
  logic [XLEN+1:0] shifted, trial;
  logic [XLEN:0]   rem_nx;
  logic [XLEN-1:0] quo_nx;

  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    trial   = shifted - {2'b00, dvs_q};
    if (trial[XLEN+1]) begin
      rem_nx = shifted[XLEN:0];
      quo_nx = {quo_q[XLEN-2:0], 1'b0};
    end else begin
      rem_nx = trial[XLEN:0];
      quo_nx = {quo_q[XLEN-2:0], 1'b1};
    end
  end

  function automatic logic [XLEN-1:0] fixup(input logic [1:0] op, input logic sa, input logic sb,
                                            input logic dz, input logic ov,
                                            input logic [XLEN-1:0] a_orig,
                                            input logic [XLEN-1:0] q, input logic [XLEN:0] r);
    logic [XLEN-1:0] rr;
    rr = r[XLEN-1:0];
    if (dz)          return op[1] ? a_orig : '1;
    else if (ov)     return op[1] ? '0 : MinNeg;
    else if (op[1])  return sa ? (~rr + 1'b1) : rr;
    else             return (sa ^ sb) ? (~q + 1'b1) : q;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      op_q        <= '0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      dz_q        <= 1'b0;
      ov_q        <= 1'b0;
      a_orig_q    <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      res_stage_q <= '0;
      res_q       <= '0;
    end else if (flush_i) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            op_q     <= op_sel_i;
            sa_q     <= sa_in;
            sb_q     <= sb_in;
            dz_q     <= dz_in;
            ov_q     <= ov_in;
            a_orig_q <= opr_a_i;
            quo_q    <= mag_a;
            dvs_q    <= mag_b;
            rem_q    <= '0;
            cnt_q    <= 5'd31;
`ifdef DIV_FAST_SPECIAL_EN
            if (dz_in || ov_in) begin
              res_stage_q <= fixup(op_sel_i, sa_in, sb_in, dz_in, ov_in, opr_a_i, '0, '0);
              state_q     <= StDone;
            end else begin
              state_q <= StCalc;
            end
`else
            state_q  <= StCalc;
`endif
          end
        end
        StCalc: begin
          quo_q <= quo_nx;
          rem_q <= rem_nx;
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd0) begin
            res_stage_q <= fixup(op_q, sa_q, sb_q, dz_q, ov_q, a_orig_q, quo_nx, rem_nx);
            state_q     <= StDone;
          end
        end
        StDone: begin
          res_q   <= res_stage_q;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ready_o = (state_q == StIdle);
  assign busy_o  = (state_q != StIdle);
  // A flush in DONE hides the new result and keeps the previous one visible.
  assign valid_o = (state_q == StDone) & ~flush_i;
  assign res_o   = valid_o ? res_stage_q : res_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed, randomized, flush, reset and handshake scenarios.
module tb_div_unit;

  logic        clk, rst_n, start, flush;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        ready, busy, valid;
  logic [31:0] res;

  int checks = 0;
  int failures = 0;

  div_unit #(.XLEN(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .op_sel_i(op), .opr_a_i(a), .opr_b_i(b),
    .flush_i(flush), .ready_o(ready), .busy_o(busy), .valid_o(valid), .res_o(res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic is_special(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    return (y == 0) || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
    int sx, sy;
    sx = x;
    sy = y;
    case (o)
      2'd0: if (y == 0) return 32'hFFFF_FFFF;
            else if (is_special(o, x, y)) return 32'h8000_0000;
            else return sx / sy;
      2'd1: if (y == 0) return 32'hFFFF_FFFF; else return x / y;
      2'd2: if (y == 0) return x;
            else if (is_special(o, x, y)) return 32'h0;
            else return sx % sy;
      default: if (y == 0) return x; else return x % y;
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
`ifdef DIV_FAST_SPECIAL_EN
    return is_special(o, x, y) ? 1 : 33;
`else
    return 33;
`endif
  endfunction

  // Issues one request from IDLE and follows it; entered and left at #1 after a rising edge.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output logic [31:0] r, output int rdy_bad);
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    lat = -1; r = '0; rdy_bad = 0;
    for (int n = 1; n <= 40; n++) begin
      if (valid) begin
        lat = n;
        r = res;
        break;
      end
      if (ready) rdy_bad++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    checks += 4;
    if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", ready); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", valid); end
    if (res !== 32'h0) begin failures++; $display("FAIL reset_res: got %h want 0", res); end
  endtask

  typedef struct {
    logic [1:0]  o;
    logic [31:0] x, y, e;
  } vec_t;

  task automatic test_directed;
    vec_t vt[9];
    int lat, bad;
    logic [31:0] r;
    vt[0] = '{2'd1, 32'd100, 32'd7, 32'd14};
    vt[1] = '{2'd3, 32'd100, 32'd7, 32'd2};
    vt[2] = '{2'd0, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2};
    vt[3] = '{2'd2, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE};
    vt[4] = '{2'd2, 32'd100, 32'hFFFF_FFF9, 32'd2};
    vt[5] = '{2'd0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF};
    vt[6] = '{2'd3, 32'h1234_5678, 32'd0, 32'h1234_5678};
    vt[7] = '{2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vt[8] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0};
    for (int i = 0; i < 9; i++) begin
      run_op(vt[i].o, vt[i].x, vt[i].y, lat, r, bad);
      checks += 3;
      if (r !== vt[i].e) begin
        failures++; $display("FAIL directed_res[%0d]: got %h want %h", i, r, vt[i].e);
      end
      if (lat != exp_lat(vt[i].o, vt[i].x, vt[i].y)) begin
        failures++;
        $display("FAIL directed_lat[%0d]: got %0d want %0d", i, lat,
                 exp_lat(vt[i].o, vt[i].x, vt[i].y));
      end
      if (bad != 0) begin
        failures++; $display("FAIL directed_ready_low[%0d]: got %0d high cycles want 0", i, bad);
      end
    end
  endtask

  task automatic test_random;
    int lat, bad;
    logic [31:0] r, x, y;
    logic [1:0] o;
    for (int i = 0; i < 30; i++) begin
      o = 2'($urandom);
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 9))
        0: y = 0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: y = $urandom_range(1, 20);
        3: y = -$urandom_range(1, 20);
        default: ;
      endcase
      run_op(o, x, y, lat, r, bad);
      checks += 2;
      if (r !== ref_model(o, x, y)) begin
        failures++;
        $display("FAIL random_res[%0d] op=%0d a=%h b=%h: got %h want %h", i, o, x, y, r,
                 ref_model(o, x, y));
      end
      if (lat != exp_lat(o, x, y)) begin
        failures++;
        $display("FAIL random_lat[%0d]: got %0d want %0d", i, lat, exp_lat(o, x, y));
      end
    end
  endtask

  task automatic test_flush;
    int lat, bad;
    logic [31:0] r;
    logic saw;
    saw = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; op = 2'd1; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin
      if (valid) saw = 1'b1;
      @(posedge clk); #1;
    end
    flush = 1'b1;
    if (valid) saw = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks += 2;
    if (ready !== 1'b1) begin failures++; $display("FAIL flush_ready: got %b want 1", ready); end
    if (saw || valid) begin failures++; $display("FAIL flush_novalid: got 1 want 0"); end
    run_op(2'd1, 32'd9, 32'd3, lat, r, bad);
    checks += 2;
    if (r !== 32'd3) begin failures++; $display("FAIL flush_next_res: got %h want 3", r); end
    if (lat != 33) begin failures++; $display("FAIL flush_next_lat: got %0d want 33", lat); end
  endtask

  task automatic test_flush_done;
    int lat, bad;
    logic [31:0] r;
    logic seen;
    run_op(2'd1, 32'd9, 32'd3, lat, r, bad);
    @(posedge clk); #1;
    start = 1'b1; op = 2'd1; a = 32'd1000; b = 32'd10;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (busy && dut.state_q == 2'd2) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    flush = 1'b1;
    #1;
    checks += 3;
    if (!seen) begin failures++; $display("FAIL flush_done_reach: got 0 want 1"); end
    if (valid !== 1'b0) begin failures++; $display("FAIL flush_done_valid: got %b want 0", valid); end
    if (res !== 32'd3) begin failures++; $display("FAIL flush_done_res: got %h want 3", res); end
    @(posedge clk); #1;
    flush = 1'b0;
    checks += 2;
    if (ready !== 1'b1) begin failures++; $display("FAIL flush_done_ready: got %b want 1", ready); end
    if (res !== 32'd3) begin failures++; $display("FAIL flush_done_hold: got %h want 3", res); end
  endtask

  task automatic test_reset_midop;
    logic saw;
    @(posedge clk); #1;
    start = 1'b1; op = 2'd1; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (ready !== 1'b1) begin failures++; $display("FAIL midrst_ready: got %b want 1", ready); end
    if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b want 0", busy); end
    if (valid !== 1'b0) begin failures++; $display("FAIL midrst_valid: got %b want 0", valid); end
    if (res !== 32'h0) begin failures++; $display("FAIL midrst_res: got %h want 0", res); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (40) begin
      if (valid) saw = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (saw) begin failures++; $display("FAIL midrst_novalid: got 1 want 0"); end
  endtask

  task automatic test_start_while_busy;
    int lat, extra;
    logic [31:0] r;
    logic busy5;
    @(posedge clk); #1;
    start = 1'b1; op = 2'd3; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1; r = '0; busy5 = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (n == 5) begin
        busy5 = busy;
        start = 1'b1; op = 2'd1; a = 32'd50; b = 32'd5;
      end
      if (n == 6) start = 1'b0;
      if (valid) begin lat = n; r = res; break; end
      @(posedge clk); #1;
    end
    extra = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (valid) extra++;
    end
    checks += 4;
    if (busy5 !== 1'b1) begin failures++; $display("FAIL busy_flag: got %b want 1", busy5); end
    if (r !== 32'd2) begin failures++; $display("FAIL busy_res: got %h want 2", r); end
    if (lat != 33) begin failures++; $display("FAIL busy_lat: got %0d want 33", lat); end
    if (extra != 0) begin failures++; $display("FAIL busy_ignored: got %0d pulses want 0", extra); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    #12;
    test_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    test_directed();
    test_random();
    test_flush();
    test_flush_done();
    test_reset_midop();
    test_start_while_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative 32-bit integer divider implementing RV32M DIV, DIVU, REM and REMU.
- Sits in the execute stage beside the combinational ALU and takes the same operand A/B buses.
- Its result enters the writeback mux alongside the ALU result.
- The pipeline stalls on a start/ready handshake and a one-cycle result valid pulse.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk_i  in  1  core clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  request valid; accepted when start_i && ready_o && !flush_i.
- op_sel_i  in  2  operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled at accept.
- opr_a_i  in  XLEN  dividend; sampled at accept.
- opr_b_i  in  XLEN  divisor; sampled at accept.
- flush_i  in  1  abort the in-flight operation (pipeline kill).
- ready_o  out  1  high only in IDLE.
- busy_o  out  1  high in CALC or DONE.
- valid_o  out  1  one-cycle pulse, result available.
- res_o  out  XLEN  quotient or remainder; holds its last value until the next valid_o.

Behaviour:
- Reset (async, rst_ni low):
  - State goes to IDLE.
  - valid_o=0, res_o=0, busy_o=0, ready_o=1 (decoded from IDLE).
  - Counter and datapath registers are cleared.
- States: IDLE, CALC, DONE.
- IDLE:
  - On accept, latch op_sel and a sign flag per operand. Sign flags are set only for DIV/REM and equal the operand's bit 31.
  - Latch operand magnitudes: two's-complement negate when the sign flag is set. Magnitude of 0x80000000 is 0x80000000 unsigned.
  - Clear the partial remainder (33 bits) and load the counter with 31.
  - Go to CALC.
- CALC: one restoring iteration per cycle.
  - Shift {rem, quo} left by one, with the dividend MSB entering rem.
  - Trial-subtract the divisor magnitude. If the result is non-negative, keep it and set quo bit0=1; otherwise restore and set bit0=0.
  - Counter decrements. The iteration at count 0 is the last, then go to DONE.
  - CALC lasts exactly 32 cycles.
- DONE (one cycle):
  - valid_o=1.
  - res_o is registered on the transition into DONE, so it is valid during the valid_o cycle.
  - Next state is IDLE.
- Sign fixup (applied to the value registered into res_o):
  - DIV: quotient negated if the sign flags differ.
  - REM: remainder negated if the dividend flag is set.
  - DIVU/REMU: raw values.
- Special cases, overriding the fixup:
  - Divisor == 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give the original dividend.
  - Signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF): DIV gives 0x80000000, REM gives 0.
  - Special-case detection happens at accept and is latched.
- Latency: accept at cycle 0, CALC at cycles 1..32, valid_o at cycle 33. ready_o is high again at cycle 34. Throughput is 1 operation per 34 cycles.
- Handshake: start_i is ignored when ready_o=0. Operands need only be stable in the accept cycle.
- Flush:
  - flush_i in any state forces IDLE on the next edge with no valid_o.
  - flush_i in DONE suppresses the valid_o pulse; res_o keeps its previous value.
  - flush_i together with start_i in IDLE: flush wins and the request is not accepted.
- Mid-operation reset: immediate return to IDLE; no valid_o.
- Width rules: the remainder path is 33 bits to hold the trial-subtract borrow. All arithmetic is unsigned on magnitudes.

Optional Feature:
- Macro: DIV_FAST_SPECIAL_EN.
- Defined: a divide-by-zero or signed-overflow request goes IDLE -> DONE directly, skipping CALC. valid_o is at cycle 1 after accept and ready_o is high at cycle 2.
- Undefined: special cases run the full 32 CALC cycles (valid_o at cycle 33) with the override applied in DONE.
- Result values are identical in both builds; only latency differs.

Test Plan:
- DIVU a=100, b=7 -> valid_o at cycle 33 after accept, res_o=14. REMU with the same operands -> 2. ready_o is low from cycle 1 through 33.
- DIV a=-100 (0xFFFFFF9C), b=7 -> 0xFFFFFFF2 (-14). REM with the same operands -> 0xFFFFFFFE (-2). REM a=100, b=-7 -> 2.
- Divisor zero: DIV a=0x12345678, b=0 -> 0xFFFFFFFF; REMU with the same operands -> 0x12345678.
  - Latency is 33 without DIV_FAST_SPECIAL_EN and 1 with it.
- Overflow: DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0x00000000.
- Flush: accept DIVU 100/7, assert flush_i at cycle 10 -> no valid_o, ready_o=1 at cycle 11.
  - Then start DIVU 9/3 -> res_o=3 after 33 cycles.
  - Also: flush_i in the DONE cycle suppresses valid_o.
- Reset/handshake: drop rst_ni at cycle 20 of an operation -> outputs go to reset values immediately.
  - start_i asserted while busy_o=1 is ignored; verify with a second request during CALC, which yields no second valid_o.
